exe_port_ctl: RTL and testbench

// Execute-side end of the issue interface. Accepts the four issued packets (mult, alu1, alu2, addr),

---
 rtl/exe_port_ctl.sv | 182 ++++++++++++++++++
 tb/tb_exe_port_ctl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_port_ctl.sv
// Execute-side issue port controller: accepts issued packets, tracks mult/addr occupancy,
// drives per-port ready, broadcasts pdest wakeups and holds memory requests until acknowledged.
module exe_port_ctl #(
  parameter int IS_INST_WIDTH   = 66,
  parameter int IS_BIT_INST_VLD = 65,
  parameter int IS_BIT_PDEST    = 44,
  parameter int IS_BIT_REGWRITE = 38,
  parameter int MUL_LAT         = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IS_INST_WIDTH-1:0] mul_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] alu1_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] alu2_ins_to_rf,
  input  logic [IS_INST_WIDTH-1:0] adr_ins_to_rf,
  input  logic                     flush,
  input  logic                     mem_ack,
  output logic [3:0]               fun_rdy_frm_exe,
  output logic [3:0]               wkup_vld,
  output logic [23:0]              wkup_preg_flat,
  output logic                     adr_req_vld,
  output logic [IS_INST_WIDTH-1:0] adr_req_pkt
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ADR_IDLE = 1'b0,
    ADR_WAIT = 1'b1
  } adr_state_t;

  function automatic logic pkt_vld(input logic [IS_INST_WIDTH-1:0] pkt);
    return pkt[IS_BIT_INST_VLD];
  endfunction

  function automatic logic pkt_rw(input logic [IS_INST_WIDTH-1:0] pkt);
    return pkt[IS_BIT_REGWRITE];
  endfunction

  function automatic logic [5:0] pkt_pdest(input logic [IS_INST_WIDTH-1:0] pkt);
    return pkt[IS_BIT_PDEST -: 6];
  endfunction

  // Only a few fields of the mult/alu packets matter here; fold the rest away.
  logic unused_pkt_bits;
  assign unused_pkt_bits = ^{mul_ins_to_rf, alu1_ins_to_rf, alu2_ins_to_rf};

  logic [3:0]       ins_vld;
  logic [3:0]       ins_rw;
  logic [3:0]       acc_p0;

  logic [CNT_W-1:0] mul_cnt_p1;
  logic [CNT_W-1:0] mul_cnt_n;
  logic [5:0]       mul_pdest_p1;
  logic             mul_rw_p1;
  logic             mul_done;
  logic             mul_wk_rw;
  logic [5:0]       mul_wk_pdest;

  adr_state_t       adr_state;
  adr_state_t       adr_state_n;
  logic             adr_wk;

  logic [3:0]       fun_rdy_n;
  logic [3:0]       wkup_vld_n;
  logic [23:0]      wkup_preg_n;

  assign ins_vld = {pkt_vld(adr_ins_to_rf), pkt_vld(alu2_ins_to_rf),
                    pkt_vld(alu1_ins_to_rf), pkt_vld(mul_ins_to_rf)};
  assign ins_rw  = {pkt_rw(adr_ins_to_rf), pkt_rw(alu2_ins_to_rf),
                    pkt_rw(alu1_ins_to_rf), pkt_rw(mul_ins_to_rf)};
  assign acc_p0  = ins_vld & fun_rdy_frm_exe & {4{~flush}};

  // Multiplier occupancy: counter loaded at accept, wakeup when it steps 1 -> 0.
  always_comb begin
    mul_cnt_n = mul_cnt_p1;
    if (flush) begin
      mul_cnt_n = '0;
    end else if (acc_p0[0]) begin
      mul_cnt_n = CNT_LOAD;
    end else if (mul_cnt_p1 != '0) begin
      mul_cnt_n = mul_cnt_p1 - CNT_ONE;
    end
  end

  always_comb begin
    mul_done     = 1'b0;
    mul_wk_rw    = mul_rw_p1;
    mul_wk_pdest = mul_pdest_p1;
    if (!flush) begin
      if (acc_p0[0] && (MUL_LAT == 1)) begin
        mul_done     = 1'b1;
        mul_wk_rw    = ins_rw[0];
        mul_wk_pdest = pkt_pdest(mul_ins_to_rf);
      end else if (mul_cnt_p1 == CNT_ONE) begin
        mul_done = 1'b1;
      end
    end
  end

  // Address handshake FSM
  always_comb begin
    adr_state_n = adr_state;
    adr_wk      = 1'b0;
    if (flush) begin
      adr_state_n = ADR_IDLE;
    end else begin
      case (adr_state)
        ADR_IDLE: begin
          if (acc_p0[3]) adr_state_n = ADR_WAIT;
        end
        ADR_WAIT: begin
          if (mem_ack) begin
            adr_state_n = ADR_IDLE;
            adr_wk      = 1'b1;
          end
        end
        default: adr_state_n = ADR_IDLE;
      endcase
    end
  end

  always_comb begin
    fun_rdy_n = 4'b0000;
    if (!flush) begin
      fun_rdy_n[0] = (mul_cnt_n == '0);
      fun_rdy_n[1] = 1'b1;
      fun_rdy_n[2] = 1'b1;
      fun_rdy_n[3] = (adr_state_n == ADR_IDLE);
    end
  end

  // Preg slices are forced to zero whenever their valid bit is low.
  always_comb begin
    wkup_vld_n[0] = mul_done && mul_wk_rw;
    wkup_vld_n[1] = acc_p0[1] && ins_rw[1];
    wkup_vld_n[2] = acc_p0[2] && ins_rw[2];
    wkup_vld_n[3] = adr_wk && adr_req_pkt[IS_BIT_REGWRITE];
    wkup_preg_n   = '0;
    if (wkup_vld_n[0]) wkup_preg_n[5:0]   = mul_wk_pdest;
    if (wkup_vld_n[1]) wkup_preg_n[11:6]  = pkt_pdest(alu1_ins_to_rf);
    if (wkup_vld_n[2]) wkup_preg_n[17:12] = pkt_pdest(alu2_ins_to_rf);
    if (wkup_vld_n[3]) wkup_preg_n[23:18] = pkt_pdest(adr_req_pkt);
  end

  // Stage p1: control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt_p1      <= '0;
      adr_state       <= ADR_IDLE;
      fun_rdy_frm_exe <= 4'b0000;
      wkup_vld        <= 4'b0000;
      wkup_preg_flat  <= '0;
      adr_req_vld     <= 1'b0;
      adr_req_pkt     <= '0;
    end else begin
      mul_cnt_p1      <= mul_cnt_n;
      adr_state       <= adr_state_n;
      fun_rdy_frm_exe <= fun_rdy_n;
      wkup_vld        <= wkup_vld_n;
      wkup_preg_flat  <= wkup_preg_n;
      adr_req_vld     <= (adr_state_n == ADR_WAIT);
      if (acc_p0[3]) adr_req_pkt <= adr_ins_to_rf;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p0[0]) begin
      mul_pdest_p1 <= pkt_pdest(mul_ins_to_rf);
      mul_rw_p1    <= ins_rw[0];
    end
  end

  // An issue to a busy port is a selector bug; the packet is dropped in hardware.
  assert property (@(posedge clk) disable iff (!rst_n)
    (flush || ((ins_vld & ~fun_rdy_frm_exe) == 4'b0000)))
    else $error("valid packet issued to a busy execute port: vld=%b rdy=%b",
                ins_vld, fun_rdy_frm_exe);

endmodule

// File: tb/tb_exe_port_ctl.sv
// Directed bench for exe_port_ctl: wakeups are tracked in a due-cycle scoreboard,
// ready/request outputs are compared at each step.
module tb_exe_port_ctl;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [65:0] mul_ins_to_rf = '0;
  logic [65:0] alu1_ins_to_rf = '0;
  logic [65:0] alu2_ins_to_rf = '0;
  logic [65:0] adr_ins_to_rf = '0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [3:0]  fun_rdy_frm_exe;
  logic [3:0]  wkup_vld;
  logic [23:0] wkup_preg_flat;
  logic        adr_req_vld;
  logic [65:0] adr_req_pkt;

  exe_port_ctl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .mul_ins_to_rf(mul_ins_to_rf), .alu1_ins_to_rf(alu1_ins_to_rf),
    .alu2_ins_to_rf(alu2_ins_to_rf), .adr_ins_to_rf(adr_ins_to_rf),
    .flush(flush), .mem_ack(mem_ack),
    .fun_rdy_frm_exe(fun_rdy_frm_exe), .wkup_vld(wkup_vld),
    .wkup_preg_flat(wkup_preg_flat), .adr_req_vld(adr_req_vld),
    .adr_req_pkt(adr_req_pkt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    int       port;
    logic [5:0] preg;
  } wk_t;

  wk_t sb[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_fail = 0;

  function automatic logic [65:0] mk(input logic [5:0] pd, input logic rw, input logic [5:0] idx);
    logic [65:0] p;
    p = '0;
    p[65]    = 1'b1;
    p[64:59] = idx;
    p[58:45] = {idx, 8'h5a};
    p[44:39] = pd;
    p[38]    = rw;
    p[37:6]  = {26'h2b3c4d5, idx};
    p[5:0]   = ~pd;
    return p;
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_wk(input int due, input int port, input logic [5:0] preg);
    wk_t e;
    e.due = due; e.port = port; e.preg = preg;
    sb.push_back(e);
  endtask

  // Drop every wakeup not yet delivered (flush or reset).
  task automatic cancel_from(input int first_due);
    wk_t keep[$];
    keep = {};
    foreach (sb[i]) if (sb[i].due < first_due) keep.push_back(sb[i]);
    sb = keep;
  endtask

  // One clock: outputs are sampled 1 time unit after the edge and wakeups checked against the scoreboard.
  task automatic tick();
    wk_t         keep[$];
    logic [3:0]  ev;
    logic [23:0] ep;
    @(posedge clk);
    cyc++;
    #1;
    ev = '0; ep = '0; keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        ev[sb[i].port] = 1'b1;
        ep[6*sb[i].port +: 6] = sb[i].preg;
      end else if (sb[i].due > cyc) begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
    check("wkup_vld", {62'b0, wkup_vld}, {62'b0, ev});
    check("wkup_preg_flat", {42'b0, wkup_preg_flat}, {42'b0, ep});
  endtask

  task automatic clear_ins();
    mul_ins_to_rf = '0; alu1_ins_to_rf = '0; alu2_ins_to_rf = '0; adr_ins_to_rf = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] apkt;

    // Reset held, then released
    tick();
    check("rdy_in_reset", {62'b0, fun_rdy_frm_exe}, 66'h0);
    check("adr_vld_in_reset", {65'b0, adr_req_vld}, 66'h0);
    check("adr_pkt_in_reset", adr_req_pkt, 66'h0);
    rst_n = 1'b1;
    tick();
    check("rdy_after_reset", {62'b0, fun_rdy_frm_exe}, 66'hf);

    // ALU1 single-cycle wakeup
    alu1_ins_to_rf = mk(6'd17, 1'b1, 6'd1);
    push_wk(cyc + 1, 1, 6'd17);
    tick(); clear_ins();
    check("rdy_alu1", {62'b0, fun_rdy_frm_exe}, 66'hf);
    tick();

    // ALU2 back-to-back
    alu2_ins_to_rf = mk(6'd40, 1'b1, 6'd2);
    push_wk(cyc + 1, 2, 6'd40);
    tick();
    alu2_ins_to_rf = mk(6'd41, 1'b1, 6'd3);
    push_wk(cyc + 1, 2, 6'd41);
    tick(); clear_ins();
    tick();

    // Multiplier latency
    mul_ins_to_rf = mk(6'd5, 1'b1, 6'd4);
    push_wk(cyc + MUL_LAT, 0, 6'd5);
    tick(); clear_ins();
    check("rdy_mul_e1", {62'b0, fun_rdy_frm_exe}, 66'he);
    tick();
    check("rdy_mul_e2", {62'b0, fun_rdy_frm_exe}, 66'he);
    tick();
    check("rdy_mul_e3", {62'b0, fun_rdy_frm_exe}, 66'hf);
    tick();

    // Address handshake with mem_ack withheld four cycles
    apkt = mk(6'd33, 1'b1, 6'd9);
    adr_ins_to_rf = apkt;
    tick(); clear_ins();
    for (int i = 0; i < 4; i++) begin
      check("adr_vld_wait", {65'b0, adr_req_vld}, 66'h1);
      check("adr_pkt_wait", adr_req_pkt, apkt);
      check("rdy_adr_wait", {62'b0, fun_rdy_frm_exe}, 66'h7);
      if (i < 3) tick();
    end
    mem_ack = 1'b1;
    push_wk(cyc + 1, 3, 6'd33);
    tick();
    mem_ack = 1'b0;
    check("adr_vld_after_ack", {65'b0, adr_req_vld}, 66'h0);
    check("rdy_after_ack", {62'b0, fun_rdy_frm_exe}, 66'hf);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("adr_vld_ack_idle", {65'b0, adr_req_vld}, 66'h0);

    // Mult cancelled by flush
    mul_ins_to_rf = mk(6'd7, 1'b1, 6'd10);
    push_wk(cyc + MUL_LAT, 0, 6'd7);
    tick(); clear_ins();
    check("rdy_mul_pre_flush", {62'b0, fun_rdy_frm_exe}, 66'he);
    flush = 1'b1;
    cancel_from(cyc + 1);
    tick();
    flush = 1'b0;
    check("rdy_flush_e2", {62'b0, fun_rdy_frm_exe}, 66'h0);
    tick();
    check("rdy_flush_e3", {62'b0, fun_rdy_frm_exe}, 66'hf);
    tick();

    // Packet arriving with flush is dropped
    alu1_ins_to_rf = mk(6'd20, 1'b1, 6'd11);
    flush = 1'b1;
    cancel_from(cyc + 1);
    tick(); clear_ins();
    flush = 1'b0;
    check("rdy_flush_drop", {62'b0, fun_rdy_frm_exe}, 66'h0);
    tick();

    // mem_ack together with flush: flush wins
    adr_ins_to_rf = mk(6'd12, 1'b1, 6'd12);
    tick(); clear_ins();
    check("adr_vld_pre_flush", {65'b0, adr_req_vld}, 66'h1);
    flush = 1'b1; mem_ack = 1'b1;
    cancel_from(cyc + 1);
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    check("adr_vld_flush_ack", {65'b0, adr_req_vld}, 66'h0);
    check("rdy_flush_ack", {62'b0, fun_rdy_frm_exe}, 66'h0);
    tick();
    check("rdy_flush_ack_back", {62'b0, fun_rdy_frm_exe}, 66'hf);

    // All four ports in the same cycle, alu2 without REGWRITE
    mul_ins_to_rf  = mk(6'd2, 1'b1, 6'd13);
    alu1_ins_to_rf = mk(6'd3, 1'b1, 6'd14);
    alu2_ins_to_rf = mk(6'd4, 1'b0, 6'd15);
    apkt = mk(6'd6, 1'b1, 6'd16);
    adr_ins_to_rf  = apkt;
    push_wk(cyc + MUL_LAT, 0, 6'd2);
    push_wk(cyc + 1, 1, 6'd3);
    tick(); clear_ins();
    check("rdy_all4_e1", {62'b0, fun_rdy_frm_exe}, 66'h6);
    check("adr_pkt_all4", adr_req_pkt, apkt);
    tick();
    check("rdy_all4_e2", {62'b0, fun_rdy_frm_exe}, 66'h6);
    mem_ack = 1'b1;
    push_wk(cyc + 1, 3, 6'd6);
    tick();
    mem_ack = 1'b0;
    check("rdy_all4_e3", {62'b0, fun_rdy_frm_exe}, 66'hf);
    tick();

    // Asynchronous reset in the middle of a multiply
    mul_ins_to_rf = mk(6'd9, 1'b1, 6'd17);
    push_wk(cyc + MUL_LAT, 0, 6'd9);
    tick(); clear_ins();
    rst_n = 1'b0;
    cancel_from(0);
    #1;
    check("rdy_async_reset", {62'b0, fun_rdy_frm_exe}, 66'h0);
    check("wkup_async_reset", {62'b0, wkup_vld}, 66'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rdy_after_mid_reset", {62'b0, fun_rdy_frm_exe}, 66'hf);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
